// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_memory_pkg
// Shared definitions for the banked data memory: access-size encodings, the
// controller state type, and the lane helpers used at store time (byte
// enables, lane replication) and at load time (alignment and extension).
// No ports; imported by data_memory_banked.
// -----------------------------------------------------------------------------
package data_memory_pkg;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10,
      SIZE_BAD  = 2'b11
   } dm_size_e;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } dm_state_e;

   // Lane k holds bits [8k+7:8k] of the 32-bit word. Little-endian puts the
   // byte at offset o in lane o; big-endian puts it in lane 3-o.
   function automatic logic [3:0] byte_enable(input dm_size_e size,
                                              input logic [1:0] offset,
                                              input logic big_endian);
      logic [3:0] be;
      be = 4'b0000;
      case (size)
         SIZE_BYTE: be = big_endian ? (4'b1000 >> offset) : (4'b0001 << offset);
         SIZE_HALF: be = big_endian ? (4'b1100 >> offset) : (4'b0011 << offset);
         SIZE_WORD: be = 4'b1111;
         default:   be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicating the right-justified store data across the word puts the
   // correct byte in every enabled lane for either endianness, so the byte
   // enables alone pick what lands in memory.
   function automatic logic [31:0] store_lanes(input logic [31:0] wdata,
                                               input dm_size_e size);
      logic [31:0] lanes;
      case (size)
         SIZE_BYTE: lanes = {4{wdata[7:0]}};
         SIZE_HALF: lanes = {2{wdata[15:0]}};
         default:   lanes = wdata;
      endcase
      return lanes;
   endfunction

   // Shift the addressed lanes down to the LSBs, then sign- or zero-extend.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input dm_size_e size,
                                               input logic [1:0] offset,
                                               input logic is_unsigned,
                                               input logic big_endian);
      logic [4:0]  sh;
      logic [31:0] s;
      logic [31:0] res;
      sh = 5'd0;
      case (size)
         SIZE_BYTE: sh = {(big_endian ? (2'd3 - offset) : offset), 3'b000};
         SIZE_HALF: sh = {(big_endian ? (2'd2 - offset) : offset), 3'b000};
         default:   sh = 5'd0;
      endcase
      s = word >> sh;
      case (size)
         SIZE_BYTE: res = is_unsigned ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         SIZE_HALF: res = is_unsigned ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         SIZE_WORD: res = word;
         default:   res = 32'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/dm_byte_bank.sv
// -----------------------------------------------------------------------------
// dm_byte_bank
// One byte lane of the data memory: a DEPTH x 8 RAM with a synchronous write
// and a registered, enabled read. The read register holds its value until
// the next enabled read.
// Ports:
//   clk      - clock, rising edge
//   i_we     - write this lane at i_addr
//   i_re     - capture mem[i_addr] into the read register
//   i_addr   - word index
//   i_wdata  - byte to write
//   o_rdata  - registered read byte
// -----------------------------------------------------------------------------
module dm_byte_bank #(
   parameter int DEPTH = 256,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [IDX_W-1:0] i_addr,
   input  logic [7:0]       i_wdata,
   output logic [7:0]       o_rdata
);

   logic [7:0] r_mem [DEPTH];
   logic [7:0] r_rdata;

   // NOTE: the storage array has no reset so it maps onto RAM macros; only
   // control state is reset, and readers never look at data they did not write.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/data_memory_banked.sv
// -----------------------------------------------------------------------------
// data_memory_banked
// Byte-addressable data memory for the MEM stage. Accepts one request on
// req_valid && req_ready, checks it for illegal size, misalignment and range,
// stores through four byte lanes, and returns loads aligned and extended after
// READ_LATENCY cycles. Errored requests never touch memory.
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 store, 0 load
//   req_size              - 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          - zero-extend loads when set
//   req_addr, req_wdata   - byte address, right-justified store data
//   resp_valid            - single-cycle response pulse
//   resp_rdata            - load result (0 for stores and errors)
//   resp_error            - response is for a rejected access
// -----------------------------------------------------------------------------
module data_memory_banked
   import data_memory_pkg::*;
#(
   parameter int ADDR_WIDTH   = 10,
   parameter int READ_LATENCY = 1,
   parameter bit BIG_ENDIAN   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error
);

   localparam int         IDX_W    = (ADDR_WIDTH > 2) ? ADDR_WIDTH - 2 : 1;
   localparam int         DEPTH    = 1 << (ADDR_WIDTH - 2);
   localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 2);

   dm_size_e          w_size;
   logic              w_accept;
   logic              w_error;
   logic              w_commit;
   logic [3:0]        w_we;
   logic              w_re;
   logic [31:0]       w_lanes;
   logic [31:0]       w_rword;
   logic [IDX_W-1:0]  w_index;

   dm_state_e         r_state;
   dm_state_e         w_next_state;
   logic [1:0]        r_cnt;
   logic [1:0]        w_next_cnt;
   logic              r_resp_valid;
   logic              w_next_resp_valid;

   logic              r_err;
   logic              r_is_load;
   dm_size_e          r_size;
   logic [1:0]        r_offset;
   logic              r_unsigned;

   assign w_size    = dm_size_e'(req_size);
   assign req_ready = (r_state == ST_IDLE);
   assign w_accept  = req_valid && req_ready;

   assign w_error = (w_size == SIZE_BAD)
                 || (w_size == SIZE_HALF && req_addr[0])
                 || (w_size == SIZE_WORD && req_addr[1:0] != 2'b00)
                 || ((req_addr >> ADDR_WIDTH) != 32'd0);

   // Reset wins over acceptance: nothing reaches the RAM while rst_n is low.
   assign w_commit = w_accept && rst_n && !w_error;
   assign w_we     = (w_commit && req_write) ? byte_enable(w_size, req_addr[1:0], BIG_ENDIAN) : 4'b0000;
   assign w_re     = w_commit && !req_write;
   assign w_lanes  = store_lanes(req_wdata, w_size);
   assign w_index  = req_addr[IDX_W+1:2];

   for (genvar k = 0; k < 4; k++) begin : g_lane
      dm_byte_bank #(
         .DEPTH (DEPTH),
         .IDX_W (IDX_W)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_we[k]),
         .i_re    (w_re),
         .i_addr  (w_index),
         .i_wdata (w_lanes[8*k +: 8]),
         .o_rdata (w_rword[8*k +: 8])
      );
   end

   // NOTE: every output of this block is assigned a default before the case,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next_state      = r_state;
      w_next_cnt        = r_cnt;
      w_next_resp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (!req_write && !w_error && READ_LATENCY > 1) begin
                  w_next_state = ST_RD_WAIT;
                  w_next_cnt   = CNT_INIT;
               end else begin
                  w_next_resp_valid = 1'b1;
               end
            end
         end
         ST_RD_WAIT: begin
            if (r_cnt != 2'd0) begin
               w_next_cnt = r_cnt - 2'd1;
            end else begin
               w_next_state      = ST_IDLE;
               w_next_resp_valid = 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cnt        <= 2'd0;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
         r_is_load    <= 1'b0;
         r_size       <= SIZE_BYTE;
         r_offset     <= 2'd0;
         r_unsigned   <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_cnt        <= w_next_cnt;
         r_resp_valid <= w_next_resp_valid;
         // Request fields are held until the response so the requester may
         // change its inputs right after acceptance.
         if (w_accept) begin
            r_err      <= w_error;
            r_is_load  <= !req_write;
            r_size     <= w_size;
            r_offset   <= req_addr[1:0];
            r_unsigned <= req_unsigned;
         end
      end
   end

   // The bank read register is stable from acceptance until the response
   // because no new request is taken in between.
   assign resp_valid = r_resp_valid;
   assign resp_error = r_resp_valid && r_err;
   assign resp_rdata = (r_resp_valid && r_is_load && !r_err)
                     ? load_extend(w_rword, r_size, r_offset, r_unsigned, BIG_ENDIAN)
                     : 32'd0;

endmodule

// File: tb/tb_data_memory_banked.sv
// -----------------------------------------------------------------------------
// tb_data_memory_banked
// Three big-endian instances with ADDR_WIDTH 10: A at READ_LATENCY 1, B at 3,
// C at 4. Request fields are shared; each instance has its own req_valid.
// -----------------------------------------------------------------------------
module tb_data_memory_banked;

   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [1:0] SX = 2'b11;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        valid_a, valid_b, valid_c;
   logic        ready_a, ready_b, ready_c;
   logic        rv_a, rv_b, rv_c;
   logic        err_a, err_b, err_c;
   logic [31:0] rd_a, rd_b, rd_c;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_memory_banked #(.ADDR_WIDTH(10), .READ_LATENCY(1), .BIG_ENDIAN(1'b1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_a), .req_ready(ready_a),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_a), .resp_rdata(rd_a), .resp_error(err_a));

   data_memory_banked #(.ADDR_WIDTH(10), .READ_LATENCY(3), .BIG_ENDIAN(1'b1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_b), .req_ready(ready_b),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_b), .resp_rdata(rd_b), .resp_error(err_b));

   data_memory_banked #(.ADDR_WIDTH(10), .READ_LATENCY(4), .BIG_ENDIAN(1'b1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .req_valid(valid_c), .req_ready(ready_c),
      .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rv_c), .resp_rdata(rd_c), .resp_error(err_c));

   // Present one request to instance inst (0=A,1=B,2=C) for exactly one edge;
   // returns 1 time unit after the acceptance edge.
   task automatic issue(input int inst, input logic w, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      valid_a = (inst == 0); valid_b = (inst == 1); valid_c = (inst == 2);
      @(posedge clk); #1;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0; valid_c = 1'b0;
      req_write = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({ready_a, rv_a, err_a} !== 3'b100 || rd_a !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_a: ready=%b valid=%b error=%b rdata=%h, required 1 0 0 00000000", ready_a, rv_a, err_a, rd_a);
      end
      n_checks++;
      if ({ready_b, rv_b, err_b, ready_c, rv_c, err_c} !== 6'b100100 || rd_b !== 32'd0 || rd_c !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_bc: b=%b%b%b c=%b%b%b rdata_b=%h rdata_c=%h, required 100 100 0 0",
                  ready_b, rv_b, err_b, ready_c, rv_c, err_c, rd_b, rd_c);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_word_big_endian();
      vec_t v[6];
      v[0] = '{1'b1, SW, 1'b0, 32'h8, 32'h11223344, 32'h00000000, 1'b0};
      v[1] = '{1'b0, SW, 1'b0, 32'h8, 32'h0,        32'h11223344, 1'b0};
      v[2] = '{1'b0, SB, 1'b1, 32'hB, 32'h0,        32'h00000044, 1'b0};
      v[3] = '{1'b0, SH, 1'b0, 32'hA, 32'h0,        32'h00003344, 1'b0};
      v[4] = '{1'b0, SB, 1'b0, 32'h8, 32'h0,        32'h00000011, 1'b0};
      v[5] = '{1'b0, SH, 1'b1, 32'h8, 32'h0,        32'h00001122, 1'b0};
      foreach (v[i]) begin
         issue(0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d);
         n_checks++;
         if (rv_a !== 1'b1 || rd_a !== v[i].exp || err_a !== v[i].err) begin
            n_fail++;
            $display("FAIL word_be[%0d]: valid=%b rdata=%h error=%b, required valid=1 rdata=%h error=%b",
                     i, rv_a, rd_a, err_a, v[i].exp, v[i].err);
         end
      end
      @(posedge clk); #1;
      n_checks++;
      if (rv_a !== 1'b0) begin
         n_fail++;
         $display("FAIL pulse_single: valid=%b, required 0", rv_a);
      end
   endtask

   task automatic test_byte_store();
      vec_t v[7];
      v[0] = '{1'b1, SW, 1'b0, 32'h4, 32'hA1B2C3D4, 32'h00000000, 1'b0};
      v[1] = '{1'b1, SB, 1'b0, 32'h4, 32'h12345680, 32'h00000000, 1'b0};
      v[2] = '{1'b0, SB, 1'b0, 32'h4, 32'h0,        32'hFFFFFF80, 1'b0};
      v[3] = '{1'b0, SB, 1'b1, 32'h4, 32'h0,        32'h00000080, 1'b0};
      v[4] = '{1'b0, SW, 1'b1, 32'h4, 32'h0,        32'h80B2C3D4, 1'b0};
      v[5] = '{1'b0, SH, 1'b0, 32'h6, 32'h0,        32'hFFFFC3D4, 1'b0};
      v[6] = '{1'b0, SB, 1'b1, 32'h5, 32'h0,        32'h000000B2, 1'b0};
      foreach (v[i]) begin
         issue(0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d);
         n_checks++;
         if (rv_a !== 1'b1 || rd_a !== v[i].exp || err_a !== v[i].err) begin
            n_fail++;
            $display("FAIL byte_store[%0d]: valid=%b rdata=%h error=%b, required valid=1 rdata=%h error=%b",
                     i, rv_a, rd_a, err_a, v[i].exp, v[i].err);
         end
      end
   endtask

   task automatic test_errors();
      vec_t v[11];
      v[0]  = '{1'b1, SW, 1'b0, 32'h0,   32'hDEADBEEF, 32'h00000000, 1'b0};
      v[1]  = '{1'b1, SH, 1'b0, 32'h3,   32'h00005555, 32'h00000000, 1'b1};
      v[2]  = '{1'b0, SW, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0};
      v[3]  = '{1'b0, SX, 1'b0, 32'h0,   32'h0,        32'h00000000, 1'b1};
      v[4]  = '{1'b1, SW, 1'b0, 32'h400, 32'h01234567, 32'h00000000, 1'b1};
      v[5]  = '{1'b0, SW, 1'b0, 32'h2,   32'h0,        32'h00000000, 1'b1};
      v[6]  = '{1'b0, SH, 1'b0, 32'h1,   32'h0,        32'h00000000, 1'b1};
      v[7]  = '{1'b0, SW, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0};
      v[8]  = '{1'b0, SW, 1'b0, 32'h400, 32'h0,        32'h00000000, 1'b1};
      v[9]  = '{1'b1, SX, 1'b0, 32'h0,   32'h99999999, 32'h00000000, 1'b1};
      v[10] = '{1'b0, SW, 1'b0, 32'h0,   32'h0,        32'hDEADBEEF, 1'b0};
      foreach (v[i]) begin
         issue(0, v[i].w, v[i].sz, v[i].u, v[i].a, v[i].d);
         n_checks++;
         if (rv_a !== 1'b1 || rd_a !== v[i].exp || err_a !== v[i].err) begin
            n_fail++;
            $display("FAIL errors[%0d]: valid=%b rdata=%h error=%b, required valid=1 rdata=%h error=%b",
                     i, rv_a, rd_a, err_a, v[i].exp, v[i].err);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_write = 1'b1; req_size = SW; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
      valid_a = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (rv_a !== 1'b1 || rd_a !== 32'd0 || err_a !== 1'b0 || ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_store: valid=%b rdata=%h error=%b ready=%b, required 1 00000000 0 1", rv_a, rd_a, err_a, ready_a);
      end
      req_write = 1'b0;
      @(posedge clk); #1;
      valid_a = 1'b0;
      n_checks++;
      if (rv_a !== 1'b1 || rd_a !== 32'h0BADF00D || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_load: valid=%b rdata=%h error=%b, required 1 0badf00d 0", rv_a, rd_a, err_a);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rv_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: valid=%b, required 0", rv_a);
      end
   endtask

   task automatic test_latency3();
      issue(1, 1'b1, SW, 1'b0, 32'h20, 32'h01020304);
      n_checks++;
      if (rv_b !== 1'b1 || err_b !== 1'b0 || ready_b !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_store: valid=%b error=%b ready=%b, required 1 0 1", rv_b, err_b, ready_b);
      end
      @(negedge clk);
      req_write = 1'b0; req_size = SW; req_unsigned = 1'b0; req_addr = 32'h20;
      valid_b = 1'b1;
      @(posedge clk); #1;                       // edge N: load accepted
      req_size = SB; req_unsigned = 1'b1; req_addr = 32'h23;   // held request
      n_checks++;
      if (ready_b !== 1'b0 || rv_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_wait1: ready=%b valid=%b, required 0 0", ready_b, rv_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ready_b !== 1'b0 || rv_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_wait2: ready=%b valid=%b, required 0 0", ready_b, rv_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ready_b !== 1'b1 || rv_b !== 1'b1 || rd_b !== 32'h01020304 || err_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_resp: ready=%b valid=%b rdata=%h error=%b, required 1 1 01020304 0", ready_b, rv_b, rd_b, err_b);
      end
      @(posedge clk); #1;                       // edge N+3: held request accepted
      valid_b = 1'b0;
      n_checks++;
      if (ready_b !== 1'b0 || rv_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_held_accept: ready=%b valid=%b, required 0 0", ready_b, rv_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rv_b !== 1'b0) begin
         n_fail++;
         $display("FAIL lat3_held_wait: valid=%b, required 0", rv_b);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rv_b !== 1'b1 || rd_b !== 32'h00000004 || ready_b !== 1'b1) begin
         n_fail++;
         $display("FAIL lat3_held_resp: valid=%b rdata=%h ready=%b, required 1 00000004 1", rv_b, rd_b, ready_b);
      end
   endtask

   task automatic test_reset_mid_read();
      int edges;
      issue(2, 1'b1, SW, 1'b0, 32'h30, 32'h55667788);
      n_checks++;
      if (rv_c !== 1'b1 || err_c !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_store: valid=%b error=%b, required 1 0", rv_c, err_c);
      end
      issue(2, 1'b0, SW, 1'b0, 32'h30, 32'h0);  // edge N: load accepted
      n_checks++;
      if (ready_c !== 1'b0 || rv_c !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_wait1: ready=%b valid=%b, required 0 0", ready_c, rv_c);
      end
      @(posedge clk); #1;                       // second wait cycle
      rst_n = 1'b0;
      req_write = 1'b1; req_size = SW; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
      valid_c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rv_c !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_drop[%0d]: valid=%b, required 0", i, rv_c);
         end
      end
      n_checks++;
      if (ready_c !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_ready: ready=%b, required 1", ready_c);
      end
      @(negedge clk);
      valid_c = 1'b0;
      rst_n   = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if (rv_c !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_late_resp[%0d]: valid=%b, required 0", i, rv_c);
         end
      end
      issue(2, 1'b0, SW, 1'b0, 32'h30, 32'h0);
      edges = 0;
      while (rv_c !== 1'b1 && edges < 8) begin
         @(posedge clk); #1;
         edges++;
      end
      n_checks++;
      if (edges + 1 != 4) begin
         n_fail++;
         $display("FAIL lat4_latency: latency=%0d, required 4", edges + 1);
      end
      n_checks++;
      if (rv_c !== 1'b1 || rd_c !== 32'h55667788 || err_c !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mem_kept: valid=%b rdata=%h error=%b, required 1 55667788 0", rv_c, rd_c, err_c);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_word_big_endian();
      test_byte_store();
      test_errors();
      test_back_to_back();
      test_latency3();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_memory_banked.md
# data_memory_banked

Parametrised successor to the single-cycle data memory. It is a byte-addressable data memory with a valid/ready request port and byte, halfword and word loads and stores. Loads can be sign- or zero-extended, and read latency is configurable. Misaligned, out-of-range and illegal-size accesses are detected and reported instead of corrupting memory. It sits in the MEM stage of the MIPS datapath, between the ALU address result and the writeback mux.

## Interface
- ADDR_WIDTH, 10, byte-address bits actually decoded; capacity = 2^ADDR_WIDTH bytes (must be ≥ 2)
- READ_LATENCY, 1, cycles from read acceptance to response, legal 1..4
- BIG_ENDIAN, 1, 1 = byte at word offset 0 is bits 31:24; 0 = little-endian
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  one-cycle pulse, response for the oldest accepted request
- resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
- resp_error  out  1  qualifies resp_valid: access rejected, memory untouched

## Operation
- Handshake: a request is accepted on a rising edge where req_valid && req_ready. There is at most one outstanding request. resp_valid has no back-pressure.
- Error check at acceptance, in priority order:
  - size 11 → error.
  - Half with addr[0] ≠ 0, or word with addr[1:0] ≠ 0 → error.
  - addr ≥ 2^ADDR_WIDTH → error.
  - Errored requests never write. They respond one cycle later with rdata 0 and error 1.
- Stores: byte enables are derived from size, addr[1:0] and BIG_ENDIAN. The write commits on the acceptance edge. The response is one cycle later with error 0 and rdata 0.
- Loads: the lanes selected by addr[1:0] are shifted to the LSBs, then extended per req_unsigned. Word loads ignore req_unsigned.
- FSM states:
  - IDLE: req_ready = 1.
  - RD_WAIT: req_ready = 0. Holds a down-counter loaded with READ_LATENCY−2.
- IDLE transitions:
  - An accepted load with READ_LATENCY > 1 goes to RD_WAIT.
  - Everything else stays in IDLE, with resp_valid registered high on the next cycle.
- RD_WAIT transitions: while the counter is nonzero, decrement. At 0, go to IDLE and register resp_valid high in the same edge.
- Memory contents are not reset. All request fields are captured at acceptance, so inputs may change afterwards.

## Timing
- Reset values: req_ready 1, resp_valid 0, resp_rdata 0, resp_error 0, FSM IDLE, counter 0.
- Latency, counted from the acceptance edge:
  - Stores and errors: resp_valid is high in the next cycle.
  - Loads: resp_valid is high READ_LATENCY cycles later.
- Throughput: one request per cycle when READ_LATENCY = 1. Otherwise req_ready is low for READ_LATENCY−1 cycles after a load.
- A load accepted in the cycle after a store to the same address returns the new data. A read in the same cycle as the store commit cannot occur.
- Reset has priority over acceptance:
  - A store presented while rst_n = 0 does not write.
  - A load pending in RD_WAIT when reset asserts is dropped and never responds.
- resp_valid high only in single cycles. Back-to-back responses are legal when latency is 1.

## Structure
- Package data_memory_pkg:
  - Size encodings SIZE_BYTE/HALF/WORD.
  - FSM state enum.
  - Function computing the 4-bit byte-enable from size, offset and endianness.
  - Function for load align and extend.
- Sub-module dm_byte_bank: one byte-wide RAM of depth 2^(ADDR_WIDTH−2) with write enable, instantiated four times, one per byte lane, indexed by addr[ADDR_WIDTH−1:2].
- Top level holds the FSM, latency counter, error checks and response registers.

## Test plan
- BIG_ENDIAN=1: sw 0x11223344 @0x8 → ok. Then lw @0x8 → 0x11223344. lbu @0xB → 0x00000044. lh @0xA → 0x00003344.
- sb 0x80 @0x4 then lb @0x4 → 0xFFFFFF80. lbu @0x4 → 0x00000080. Neighbouring bytes @0x5..0x7 unchanged.
- Misaligned sh @0x3 → resp_error 1 one cycle later, rdata 0. A following lw @0x0 shows the old contents. size 11 → error. addr 0x400 with ADDR_WIDTH=10 → error.
- READ_LATENCY=3: lw accepted at edge N → req_ready low for the two cycles after N. resp_valid is high only in cycle N+3. A req_valid held during the wait is accepted at edge N+3.
- Back-to-back at latency 1: sw @0x10, then lw @0x10 on the next edge → the second response returns the new data. The two resp_valid pulses are consecutive.
- Reset mid-read at latency 4 (assert rst_n=0 at the second wait cycle): no resp_valid, req_ready 1 after reset. A store held during reset → memory unchanged.
